// File: rtl/icache_nb.sv
// Non-blocking N-way instruction cache: lookup side serves one request at a time,
// fill side streams one line with critical-word-first wrap and hit-under-fill.
module icache_nb #(
  parameter int WAYS   = 2,
  parameter int LINES  = 64,
  parameter int LINE_W = 8,
  parameter int WRAP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifence,
  input  logic        cache_en,
  input  logic        abort,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [29:0] mem_addr,
  output logic [4:0]  mem_rlen,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int WB  = $clog2(LINE_W);
  localparam int SB  = $clog2(LINES);
  localparam int TB  = 30 - SB - WB;
  localparam int WYB = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOOKUP = 2'd1, ST_WAIT_FILL = 2'd2, ST_SWEEP = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [LINES-1:0]  valid_r [WAYS];
  logic [TB-1:0]     tag_r   [WAYS][LINES];
  logic [31:0]       ram_r   [WAYS][LINES*LINE_W];
  logic [31:0]       ram_q_r [WAYS];

  logic              fill_busy_r, fill_cached_r, mem_req_r;
  logic [SB-1:0]     fill_set_r;
  logic [TB-1:0]     fill_tag_r;
  logic [WB-1:0]     fill_crit_r, fill_cnt_r;
  logic [LINE_W-1:0] fill_bitmap_r;
  logic [WYB-1:0]    victim_r, rr_r;
  logic [29:0]       mem_addr_r;
  logic [4:0]        mem_rlen_r;

  logic [29:0]       addr_r;
  logic [WB-1:0]     want_word_r;
  logic              rsp_v_r, byp_v_r;
  logic [31:0]       byp_data_r;
  logic [WYB-1:0]    hit_way_r;
  logic [SB-1:0]     sweep_cnt_r;
  logic              ifence_pend_r;

  logic [29:0]       lk_addr_s;
  logic [SB-1:0]     lk_set_s;
  logic [TB-1:0]     lk_tag_s;
  logic [WB-1:0]     lk_word_s, beat_word_s;
  logic [LINE_W-1:0] arrived_s;
  logic              tag_hit_s, fl_match_s, lk_hit_s, lk_wait_s, lk_go_s, acc_s;
  logic [WYB-1:0]    tag_way_s;
  logic              beat_s, line_done_s, line_complete_s, ack_s, fill_start_s, wf_beat_s, sweep_go_s;
  logic              unused_s;

  assign unused_s        = ^req_addr[1:0];
  assign lk_addr_s       = (state_r == ST_LOOKUP) ? addr_r : req_addr[31:2];
  assign lk_word_s       = lk_addr_s[WB-1:0];
  assign lk_set_s        = lk_addr_s[WB +: SB];
  assign lk_tag_s        = lk_addr_s[29 -: TB];
  assign acc_s           = req_valid & req_ready;
  assign lk_go_s         = acc_s | ((state_r == ST_LOOKUP) & ~fill_busy_r & ~abort);
  assign ack_s           = mem_req_r & mem_ack;
  assign beat_s          = mem_rvalid & fill_busy_r;
  assign beat_word_s     = (WRAP != 0) ? (fill_crit_r + fill_cnt_r) : fill_cnt_r;
  assign line_done_s     = beat_s & (fill_cnt_r == (fill_cached_r ? WB'(LINE_W - 1) : WB'(0)));
  assign line_complete_s = line_done_s & fill_cached_r;
  // A beat landing this very cycle counts as arrived, so same-cycle lookups never stall on it.
  assign arrived_s       = fill_bitmap_r | ((beat_s & fill_cached_r) ? (LINE_W'(1) << beat_word_s) : '0);
  assign fl_match_s      = fill_busy_r & fill_cached_r & (fill_set_r == lk_set_s) & (fill_tag_r == lk_tag_s);
  assign lk_hit_s        = cache_en & (fl_match_s ? arrived_s[lk_word_s] : tag_hit_s);
  assign lk_wait_s       = cache_en & fl_match_s & ~arrived_s[lk_word_s];
  assign fill_start_s    = lk_go_s & ~lk_hit_s & ~lk_wait_s & ~fill_busy_r;
  assign wf_beat_s       = (state_r == ST_WAIT_FILL) & beat_s & (~fill_cached_r | (beat_word_s == want_word_r));
  assign sweep_go_s      = (state_r == ST_IDLE) & ifence_pend_r & (~fill_busy_r | line_done_s) & ~rsp_v_r;
  assign mem_req         = mem_req_r;
  assign mem_addr        = mem_addr_r;
  assign mem_rlen        = mem_rlen_r;

  // Tag compare across all ways; lowest matching way wins.
  always_comb begin
    tag_hit_s = 1'b0;
    tag_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      tag_way_s = (!tag_hit_s && valid_r[w][lk_set_s] && (tag_r[w][lk_set_s] == lk_tag_s)) ? WYB'(w) : tag_way_s;
      tag_hit_s = tag_hit_s | (valid_r[w][lk_set_s] & (tag_r[w][lk_set_s] == lk_tag_s));
    end
  end

  // Lookup-side state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Lookup-side next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sweep_go_s)                 state_s = ST_SWEEP;
        else if (lk_go_s && !lk_hit_s)  state_s = (lk_wait_s || !fill_busy_r) ? ST_WAIT_FILL : ST_LOOKUP;
        else                            state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (abort)        state_s = ST_IDLE;
        else if (lk_go_s) state_s = lk_hit_s ? ST_IDLE : ST_WAIT_FILL;
        else              state_s = ST_LOOKUP;
      end
      ST_WAIT_FILL: begin
        if (abort || wf_beat_s) state_s = ST_IDLE;
        else                    state_s = ST_WAIT_FILL;
      end
      ST_SWEEP: begin
        if (!ifence && sweep_cnt_r == SB'(LINES - 1)) state_s = ST_IDLE;
        else                                          state_s = ST_SWEEP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Fetch-facing outputs.
  always_comb begin
    req_ready = (state_r == ST_IDLE) & ~ifence_pend_r & ~abort;
    rsp_valid = ~abort & (rsp_v_r | wf_beat_s);
    if (wf_beat_s)    rsp_data = mem_rdata;
    else if (byp_v_r) rsp_data = byp_data_r;
    else              rsp_data = ram_q_r[hit_way_r];
  end

  // Per-request lookup registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_r <= 1'b0; byp_v_r <= 1'b0; byp_data_r <= 32'd0;
      addr_r <= 30'd0; want_word_r <= '0; hit_way_r <= '0;
    end else begin
      rsp_v_r <= lk_go_s & lk_hit_s;
      if (lk_go_s) begin
        addr_r      <= lk_addr_s;
        want_word_r <= lk_word_s;
        hit_way_r   <= fl_match_s ? victim_r : tag_way_s;
        byp_v_r     <= fl_match_s & beat_s & (beat_word_s == lk_word_s);
        byp_data_r  <= mem_rdata;
      end
    end
  end

  // Data RAM: fill writes, registered lookup reads of every way.
  always_ff @(posedge clk) begin
    if (beat_s && fill_cached_r) ram_r[victim_r][{fill_set_r, beat_word_s}] <= mem_rdata;
    if (lk_go_s) begin
      for (int w = 0; w < WAYS; w++) ram_q_r[w] <= ram_r[w][{lk_set_s, lk_word_s}];
    end
  end

  // Tag array, written when a line completes.
  always_ff @(posedge clk) begin
    if (line_complete_s) tag_r[victim_r][fill_set_r] <= fill_tag_r;
  end

  // Valid bits: sweep clear, victim invalidate at grant, allocate on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
    end else if (state_r == ST_SWEEP) begin
      for (int w = 0; w < WAYS; w++) valid_r[w][sweep_cnt_r] <= 1'b0;
    end else if (ack_s && fill_cached_r) begin
      valid_r[rr_r][fill_set_r] <= 1'b0;
    end else if (line_complete_s) begin
      valid_r[victim_r][fill_set_r] <= 1'b1;
    end
  end

  // Fill engine and L1 request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_busy_r <= 1'b0; fill_cached_r <= 1'b0; mem_req_r <= 1'b0;
      fill_set_r <= '0; fill_tag_r <= '0; fill_crit_r <= '0; fill_cnt_r <= '0;
      fill_bitmap_r <= '0; victim_r <= '0; rr_r <= '0; mem_addr_r <= 30'd0; mem_rlen_r <= 5'd0;
    end else if (fill_start_s) begin
      fill_busy_r   <= 1'b1;
      fill_cached_r <= cache_en;
      fill_set_r    <= lk_set_s;
      fill_tag_r    <= lk_tag_s;
      fill_crit_r   <= lk_word_s;
      fill_cnt_r    <= '0;
      fill_bitmap_r <= '0;
      mem_req_r     <= 1'b1;
      mem_addr_r    <= (WRAP != 0 || !cache_en) ? lk_addr_s : {lk_addr_s[29:WB], {WB{1'b0}}};
      mem_rlen_r    <= cache_en ? 5'(LINE_W - 1) : 5'd0;
    end else begin
      if (ack_s) begin
        mem_req_r <= 1'b0;
        if (fill_cached_r) begin
          victim_r <= rr_r;
          rr_r     <= (rr_r == WYB'(WAYS - 1)) ? '0 : rr_r + WYB'(1);
        end
      end
      if (beat_s) begin
        fill_cnt_r <= fill_cnt_r + WB'(1);
        if (fill_cached_r) fill_bitmap_r[beat_word_s] <= 1'b1;
        if (line_done_s)   fill_busy_r <= 1'b0;
      end
    end
  end

  // ifence latch and sweep counter; a new ifence mid-sweep restarts from set 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifence_pend_r <= 1'b0;
      sweep_cnt_r   <= '0;
    end else if (state_r == ST_SWEEP) begin
      sweep_cnt_r <= ifence ? '0 : sweep_cnt_r + SB'(1);
    end else begin
      sweep_cnt_r <= '0;
      if (sweep_go_s)  ifence_pend_r <= 1'b0;
      else if (ifence) ifence_pend_r <= 1'b1;
    end
  end

  icache_nb_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_busy  (fill_busy_r),
    .mem_req    (mem_req_r),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid)
  );
endmodule

// Protocol checker: beats only during an open fill, acks only against a raised request.
module icache_nb_chk (
  input logic clk,
  input logic rst_n,
  input logic fill_busy,
  input logic mem_req,
  input logic mem_ack,
  input logic mem_rvalid
);
  a_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid |-> fill_busy);
  a_ack_no_req:  assert property (@(posedge clk) disable iff (!rst_n) mem_ack |-> mem_req);
endmodule
